sdft_sweeper: RTL and testbench

- Controller on the other end of the sdft bin interface. It accepts ADC samples and display line requests, drives sdft start/read/bin_addr, and reads bin_out.
- Each time a line is requested, it sweeps all FREQ_BINS magnitudes and writes saturated PIX_W-bit pixels into the waterfall line buffer write port.
- Sits between the ADC sampler, the sdft core and the waterfall display line RAM.

---
 rtl/sdft_sweeper_if.sv | 37 +++
 rtl/sdft_sweeper.sv | 206 ++++++++++++++++++++
 tb/tb_sdft_sweeper.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdft_sweeper_if.sv
// Bus bundle between the sweeper and its downstream peers: the sdft bin
// interface (sample/start/read/bin_addr out, bin_out/ready back) and the
// waterfall line-buffer write port (en/addr/data).
// master = sweeper side, slave = sdft core + line RAM side.
interface sdft_sweeper_if #(
  parameter int DATA_W    = 8,
  parameter int FREQ_BINS = 64,
  parameter int FREQ_W    = 16,
  parameter int PIX_W     = 8
);
  localparam int AW = (FREQ_BINS > 1) ? $clog2(FREQ_BINS) : 1;

  // sdft control and bin read-back
  logic [DATA_W-1:0] sdft_sample;
  logic              sdft_start;
  logic              sdft_read;
  logic [AW-1:0]     sdft_bin_addr;
  logic [FREQ_W-1:0] sdft_bin_out;
  logic              sdft_ready;

  // waterfall line buffer write port
  logic              line_wr_en;
  logic [AW-1:0]     line_wr_addr;
  logic [PIX_W-1:0]  line_wr_data;

  modport master (
    output sdft_sample, sdft_start, sdft_read, sdft_bin_addr,
    output line_wr_en, line_wr_addr, line_wr_data,
    input  sdft_bin_out, sdft_ready
  );

  modport slave (
    input  sdft_sample, sdft_start, sdft_read, sdft_bin_addr,
    input  line_wr_en, line_wr_addr, line_wr_data,
    output sdft_bin_out, sdft_ready
  );
endinterface

// File: rtl/sdft_sweeper.sv
// Purpose: drives the sdft core (sample start / bin read sweep) and writes
//   saturated bin magnitudes as one waterfall line per line request.
// Latency: sample -> start in 2 cycles from idle; line_req -> first pixel write
//   in 3+READ_LAT cycles, line_done one cycle after the last pixel.
// Backpressure: waits on sdft_ready; one buffered sample (extra samples are
//   dropped and flagged by sticky overrun); line requests merge.
// Ports: clk, reset_n (async active-low); sample_in/sample_valid from ADC;
//   line_req from display; line_done/overrun status; bus = sdft + line RAM.
module sdft_sweeper #(
  parameter int DATA_W    = 8,
  parameter int FREQ_BINS = 64,
  parameter int FREQ_W    = 16,
  parameter int PIX_W     = 8,
  parameter int READ_LAT  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              line_req,
  output logic              line_done,
  output logic              overrun,
  sdft_sweeper_if.master    bus
);

  localparam int AW = (FREQ_BINS > 1) ? $clog2(FREQ_BINS) : 1;
  localparam int DW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [AW-1:0] LAST_BIN   = AW'(FREQ_BINS - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(READ_LAT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CALC,
    ST_ARM,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] sample_buf;
  logic              sample_pend;
  logic              line_pend;
  logic              overrun_q;
  logic              calc_first;
  logic [AW-1:0]     bin_cnt;
  logic [DW-1:0]     drain_cnt;

  // Capture delay line: one slot per cycle of sdft read latency.
  logic [READ_LAT-1:0] pipe_vld;
  logic [AW-1:0]       pipe_addr [READ_LAT];

  logic              start_c;
  logic              read_c;
  logic [AW-1:0]     addr_c;
  logic              done_c;
  logic              consume;
  logic [PIX_W-1:0]  pix;
  logic              wr_en;

  // ---------------------------------------------------------------------
  // Next-state / control decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    read_c    = 1'b0;
    addr_c    = '0;
    done_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        // Samples win over lines so the sdft never misses input.
        if (bus.sdft_ready) begin
          if (sample_pend)    state_nxt = ST_START;
          else if (line_pend) state_nxt = ST_ARM;
        end
      end
      ST_START: begin
        start_c   = 1'b1;
        state_nxt = ST_CALC;
      end
      ST_CALC: begin
        // ready is stale in the first cycle; the sdft only registers busy then.
        if (!calc_first && bus.sdft_ready) state_nxt = ST_IDLE;
      end
      ST_ARM: begin
        read_c    = 1'b1;
        state_nxt = ST_READ;
      end
      ST_READ: begin
        read_c = 1'b1;
        addr_c = bin_cnt;
        if (bin_cnt == LAST_BIN) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt == LAST_DRAIN) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_c    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign consume = (state == ST_START);

  // ---------------------------------------------------------------------
  // State register and counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      calc_first <= 1'b0;
      bin_cnt    <= '0;
      drain_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      calc_first <= (state == ST_START);
      bin_cnt    <= (state == ST_READ)  ? bin_cnt + AW'(1)   : '0;
      drain_cnt  <= (state == ST_DRAIN) ? drain_cnt + DW'(1) : '0;
    end
  end

  // ---------------------------------------------------------------------
  // Sample buffer, pending flags, overrun
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_buf  <= '0;
      sample_pend <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (sample_valid) begin
        // The START cycle frees the slot, so a coincident sample still fits.
        if (!sample_pend || consume) begin
          sample_buf  <= sample_in;
          sample_pend <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (consume) begin
        sample_pend <= 1'b0;
      end
    end
  end

  // A request during a sweep re-arms the flag, giving exactly one more sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_pend <= 1'b0;
    end else if (line_req) begin
      line_pend <= 1'b1;
    end else if (state == ST_ARM) begin
      line_pend <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Capture delay line: address issued in READ lands READ_LAT cycles later.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_addr[i] <= '0;
    end else begin
      pipe_vld[0]  <= (state == ST_READ);
      pipe_addr[0] <= bin_cnt;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pixel saturation: anything above the pixel range clips to all ones.
  // ---------------------------------------------------------------------
  generate
    if (FREQ_W > PIX_W) begin : g_sat
      logic over;
      assign over = |bus.sdft_bin_out[FREQ_W-1:PIX_W];
      assign pix  = over ? {PIX_W{1'b1}} : bus.sdft_bin_out[PIX_W-1:0];
    end else begin : g_nosat
      assign pix = PIX_W'(bus.sdft_bin_out);
    end
  endgenerate

  assign wr_en = pipe_vld[READ_LAT-1];

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.sdft_sample   = sample_buf;
  assign bus.sdft_start    = start_c;
  assign bus.sdft_read     = read_c;
  assign bus.sdft_bin_addr = addr_c;
  assign bus.line_wr_en    = wr_en;
  assign bus.line_wr_addr  = wr_en ? pipe_addr[READ_LAT-1] : '0;
  assign bus.line_wr_data  = wr_en ? pix : '0;
  assign line_done         = done_c;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_sdft_sweeper.sv
// Bench for sdft_sweeper: behavioural sdft model (2-cycle bin read latency,
// multi-cycle calc with a stale ready in the first cycle), scoreboards for
// expected start samples and expected line-buffer writes.
module tb_sdft_sweeper;

  localparam int CALC_CYC = 6;
  localparam int NB       = 64;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       line_req;
  logic       line_done;
  logic       overrun;

  always #5 clk = ~clk;

  sdft_sweeper_if #(.DATA_W(8), .FREQ_BINS(NB), .FREQ_W(16), .PIX_W(8)) bus ();

  sdft_sweeper #(
    .DATA_W(8), .FREQ_BINS(NB), .FREQ_W(16), .PIX_W(8), .READ_LAT(2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .line_req     (line_req),
    .line_done    (line_done),
    .overrun      (overrun),
    .bus          (bus.master)
  );

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // sdft model
  // ---------------------------------------------------------------------
  int          mode = 0;
  logic        m_rd, m_go;
  logic [5:0]  m_addr;
  logic [15:0] m_bin;
  int          m_busy;

  function automatic logic [15:0] fbin(input int k);
    if (mode == 0) return 16'(k * 3);
    case (k % 4)
      0:       return 16'h0100;
      1:       return 16'h00FF;
      2:       return 16'hFFFF;
      default: return 16'(k * 5);
    endcase
  endfunction

  function automatic logic [7:0] pix(input logic [15:0] v);
    if (v > 16'd255) return 8'hFF;
    return v[7:0];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rd   <= 1'b0;
      m_go   <= 1'b0;
      m_addr <= '0;
      m_bin  <= '0;
      m_busy <= 0;
    end else begin
      m_rd   <= bus.sdft_read;
      m_addr <= bus.sdft_bin_addr;
      m_bin  <= m_rd ? fbin(int'(m_addr)) : 16'h0;
      m_go   <= bus.sdft_start;
      if (m_go)            m_busy <= CALC_CYC;
      else if (m_busy > 0) m_busy <= m_busy - 1;
    end
  end

  assign bus.sdft_bin_out = m_bin;
  assign bus.sdft_ready   = (m_busy == 0) && !m_rd;

  // ---------------------------------------------------------------------
  // Scoreboards and monitors
  // ---------------------------------------------------------------------
  typedef struct {
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wr_q [$];
  logic [7:0] start_q [$];

  int   cyc = 0;
  int   n_start = 0, n_wr = 0, n_done = 0, viol = 0;
  int   last_wr_cyc = -10, start_cyc = 0, read_rise_cyc = 0;
  logic prev_start = 1'b0, prev_read = 1'b0;
  wr_t  mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.sdft_start) begin
      n_start++;
      start_cyc = cyc;
      if (start_q.size() == 0) chk("start_unexpected", 1, 0);
      else chk("start_sample", 32'(bus.sdft_sample), 32'(start_q.pop_front()));
    end
    if ((bus.sdft_start || bus.sdft_read) && (m_go || m_busy != 0)) viol++;
    if (bus.sdft_start && bus.sdft_read) viol++;
    if (bus.sdft_start && prev_start) viol++;
    prev_start = bus.sdft_start;
    if (bus.sdft_read && !prev_read) read_rise_cyc = cyc;
    prev_read = bus.sdft_read;

    if (bus.line_wr_en) begin
      n_wr++;
      last_wr_cyc = cyc;
      if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        mon_e = wr_q.pop_front();
        chk("wr_addr", 32'(bus.line_wr_addr), 32'(mon_e.a));
        chk("wr_data", 32'(bus.line_wr_data), 32'(mon_e.d));
      end
    end
    if (line_done) begin
      n_done++;
      chk("done_timing", 32'(cyc), 32'(last_wr_cyc + 1));
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic push_line();
    wr_t t;
    for (int k = 0; k < NB; k++) begin
      t.a = 6'(k);
      t.d = pix(fbin(k));
      wr_q.push_back(t);
    end
  endtask

  task automatic drive(input logic sv, input logic [7:0] v, input logic lr);
    @(posedge clk); #1;
    sample_in    = v;
    sample_valid = sv;
    line_req     = lr;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    line_req     = 1'b0;
  endtask

  // Wait until both scoreboards are drained and the model has been idle
  // long enough to cover a full calc.
  task automatic wait_quiet(input string tag);
    int stable = 0;
    for (int i = 0; i < 3000 && stable < CALC_CYC + 6; i++) begin
      @(negedge clk);
      if (start_q.size() == 0 && wr_q.size() == 0 && m_busy == 0 && !m_go &&
          !bus.sdft_read && !m_rd) stable++;
      else stable = 0;
    end
    if (stable < CALC_CYC + 6) chk({"timeout_", tag}, 0, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_start"},  32'(bus.sdft_start),    0);
    chk({tag, "_read"},   32'(bus.sdft_read),     0);
    chk({tag, "_addr"},   32'(bus.sdft_bin_addr), 0);
    chk({tag, "_sample"}, 32'(bus.sdft_sample),   0);
    chk({tag, "_wr_en"},  32'(bus.line_wr_en),    0);
    chk({tag, "_wr_addr"},32'(bus.line_wr_addr),  0);
    chk({tag, "_wr_data"},32'(bus.line_wr_data),  0);
    chk({tag, "_done"},   32'(line_done),         0);
    chk({tag, "_overrun"},32'(overrun),           0);
  endtask

  // ---------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------
  initial begin
    int snap_done, snap_wr, snap_start;
    bit hit;

    reset_n      = 1'b0;
    sample_in    = 8'h00;
    sample_valid = 1'b0;
    line_req     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;

    // Single sample: one start pulse carrying 0x80, no read.
    start_q.push_back(8'h80);
    drive(1'b1, 8'h80, 1'b0);
    wait_quiet("t1");
    chk("t1_starts", 32'(n_start), 1);
    chk("t1_no_writes", 32'(n_wr), 0);

    // Ramp sweep: bin k -> k*3.
    mode = 0;
    push_line();
    snap_done = n_done;
    snap_wr   = n_wr;
    drive(1'b0, 8'h00, 1'b1);
    wait_quiet("t2");
    chk("t2_done", 32'(n_done), 32'(snap_done + 1));
    chk("t2_writes", 32'(n_wr - snap_wr), NB);

    // Saturation sweep: 0x0100, 0x00FF, 0xFFFF, k*5 repeating.
    mode = 1;
    push_line();
    snap_done = n_done;
    drive(1'b0, 8'h00, 1'b1);
    wait_quiet("t3");
    chk("t3_done", 32'(n_done), 32'(snap_done + 1));
    chk("t3_overrun_clear", 32'(overrun), 0);

    // Two samples during a sweep: the second is dropped.
    mode = 0;
    push_line();
    start_q.push_back(8'h10);
    snap_start = n_start;
    drive(1'b0, 8'h00, 1'b1);
    repeat (10) @(posedge clk);
    drive(1'b1, 8'h10, 1'b0);
    repeat (10) @(posedge clk);
    drive(1'b1, 8'h20, 1'b0);
    wait_quiet("t4");
    chk("t4_overrun", 32'(overrun), 1);
    chk("t4_starts", 32'(n_start - snap_start), 1);

    // Sample and line request together: start first, read only after calc.
    push_line();
    start_q.push_back(8'h33);
    drive(1'b1, 8'h33, 1'b1);
    wait_quiet("t5");
    chk("t5_read_after_calc", 32'(read_rise_cyc > start_cyc + CALC_CYC), 1);

    // Reset in the middle of a sweep.
    push_line();
    snap_done = n_done;
    drive(1'b0, 8'h00, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (bus.sdft_read && bus.sdft_bin_addr == 6'd30) hit = 1'b1;
    end
    chk("t6_reached_bin30", 32'(hit), 1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t6_abort");
    wr_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    chk("t6_no_partial_done", 32'(n_done), 32'(snap_done));
    push_line();
    snap_wr = n_wr;
    drive(1'b0, 8'h00, 1'b1);
    wait_quiet("t6b");
    chk("t6_full_sweep", 32'(n_wr - snap_wr), NB);
    chk("t6_done", 32'(n_done), 32'(snap_done + 1));

    chk("protocol_violations", 32'(viol), 0);
    chk("wr_queue_empty", 32'(wr_q.size()), 0);
    chk("start_queue_empty", 32'(start_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
